mc_controller: RTL and testbench

Multicycle control unit for the 32-bit ARM-subset datapath. It sits directly upstream of the ALU and drives `ALUControl` and all datapath mux selects and write enables from the fetched instruction fields. It also owns the NZCV flag register, which it loads from the ALU's `ALUFlags`. It sequences each instruction through fetch, decode, execute, memory and writeback states, and gates architectural writes on the ARM condition field.

---
 rtl/mc_controller.sv | 178 +++++++++++++++++
 tb/tb_mc_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle control unit for the ARM-subset datapath: instruction sequencing FSM,
// ALU decode, NZCV flag register and condition-gated architectural writes.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] flags_reg;
  logic       condex_reg;

  logic       cond_ex;
  logic       next_pc, reg_w, mem_w, branch, ir_w, pcs;
  logic [2:0] alu_dec;
  logic [3:0] cmd;
  logic       i_bit, s_bit, no_write;
  logic       flag_n, flag_z, flag_c, flag_v;

  assign i_bit    = Funct[5];
  assign cmd      = Funct[4:1];
  assign s_bit    = Funct[0];
  assign no_write = (cmd == 4'b1010);
  assign {flag_n, flag_z, flag_c, flag_v} = flags_reg;

  always_comb begin
    case (cmd)
      4'b0100: alu_dec = 3'b000;
      4'b0010: alu_dec = 3'b001;
      4'b1010: alu_dec = 3'b001;
      4'b0000: alu_dec = 3'b010;
      4'b1100: alu_dec = 3'b011;
      4'b1111: alu_dec = 3'b100;
      default: alu_dec = 3'b000;
    endcase
  end

  always_comb begin
    case (Cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= FETCH;
      flags_reg  <= 4'b0000;
      condex_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == DECODE)
        condex_reg <= cond_ex;
      // Uses the condition latched in DECODE, so a failed instruction never touches flags.
      if ((state_reg == EXECUTER || state_reg == EXECUTEI) && s_bit && condex_reg) begin
        flags_reg[3:2] <= ALUFlags[3:2];
        if (alu_dec[2:1] == 2'b00)
          flags_reg[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    next_pc    = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    ir_w       = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 3'b000;
    case (state_reg)
      FETCH: begin
        ir_w       = 1'b1;
        next_pc    = 1'b1;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        state_next = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b01:   state_next = MEMADR;
          2'b00:   state_next = i_bit ? EXECUTEI : EXECUTER;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        state_next = s_bit ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc     = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        reg_w      = 1'b1;
        state_next = FETCH;
      end
      MEMWR: begin
        AdrSrc     = 1'b1;
        mem_w      = 1'b1;
        state_next = FETCH;
      end
      EXECUTER: begin
        ALUControl = alu_dec;
        state_next = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_w      = ~no_write;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        branch     = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // Writes to R15 are redirected into the PC rather than the register file.
  assign pcs       = ((Rd == 4'b1111) && reg_w) || branch;
  assign PCWrite   = ~reset & (next_pc | (pcs & condex_reg));
  assign RegWrite  = ~reset & reg_w & condex_reg & ~pcs;
  assign MemWrite  = ~reset & mem_w & condex_reg;
  assign IRWrite   = ~reset & ir_w;
  assign RegSrc    = {(Op == 2'b01) && !s_bit, (Op == 2'b10)};
  assign ImmSrc    = Op;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: a per-instruction reference model queues the
// expected output vector for every cycle; a negedge monitor pops and compares.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] Cond = 4'h0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'h00;
  logic [3:0] Rd = 4'h0;
  logic [3:0] ALUFlags = 4'h0;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0] ALUControl;

  mc_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] val;
    logic [17:0] mask;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int instr_no = 0;
  logic [3:0] m_flags = 4'h0;

  wire [17:0] act = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
                     ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 3'd0;
      4'b0010: return 3'd1;
      4'b1010: return 3'd1;
      4'b0000: return 3'd2;
      4'b1100: return 3'd3;
      4'b1111: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  task automatic push(input string nm, input bit pcw, input bit memw, input bit regw,
                      input bit irw, input bit adr, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] r, input logic [2:0] alc);
    exp_t e;
    logic [1:0] rs;
    rs = {(Op == 2'b01) && !Funct[0], (Op == 2'b10)};
    e.val  = {pcw, memw, regw, irw, adr, rs, a, b, r, Op, alc};
    e.mask = '1;
    e.name = $sformatf("i%0d_%s", instr_no, nm);
    pend.push_back(e);
  endtask

  // Drives one instruction and queues expectations; limit truncates it so a reset can cut in.
  task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] rd, input logic [3:0] af, input int limit);
    bit cx, wr, pcs;
    logic [2:0] alc;
    int n;
    Cond = c; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
    instr_no++;
    pend.delete();
    cx  = cond_holds(c, m_flags);
    alc = alu_of(fn[4:1]);
    push("fetch",  1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 3'd0);
    push("decode", 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 3'd0);
    case (op)
      2'b01: begin
        push("memadr", 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 3'd0);
        if (fn[0]) begin
          push("memrd", 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0);
          push("memwb", cx && rd == 4'hF, 0, cx && rd != 4'hF, 0, 0, 2'b00, 2'b00, 2'b01, 3'd0);
        end else begin
          push("memwr", 0, cx, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0);
        end
      end
      2'b00: begin
        push("execute", 0, 0, 0, 0, 0, 2'b00, fn[5] ? 2'b01 : 2'b00, 2'b00, alc);
        wr  = (fn[4:1] != 4'b1010);
        pcs = wr && rd == 4'hF;
        push("aluwb", pcs && cx, 0, wr && cx && !pcs, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0);
      end
      2'b10: push("branch", cx, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'd0);
      default: ;
    endcase
    n = pend.size();
    if (limit > n) limit = n;
    for (int k = 0; k < limit; k++) exp_q.push_back(pend[k]);
    if (limit == n && op == 2'b00 && fn[0] && cx) begin
      m_flags[3:2] = af[3:2];
      if (alc == 3'd0 || alc == 3'd1) m_flags[1:0] = af[1:0];
    end
    repeat (limit) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    exp_t e;
    reset = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      e.val  = '0;
      e.mask = 18'h3C000;
      e.name = $sformatf("reset_writes_after_i%0d", instr_no);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    m_flags = 4'h0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ((act & mon_e.mask) !== (mon_e.val & mon_e.mask)) begin
        errors++;
        $display("FAIL %s: got %05h expected %05h (mask %05h)",
                 mon_e.name, act & mon_e.mask, mon_e.val & mon_e.mask, mon_e.mask);
      end
    end
  end

  logic [3:0] cmds [0:5] = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100, 4'b1111};

  initial begin
    logic [3:0] rc, rcmd, rrd;
    logic [1:0] rop;
    @(posedge clk);
    #1;
    do_reset(2);
    run_instr(4'hE, 2'b00, 6'b001000, 4'd3, 4'h0, 99);  // ADD imm
    run_instr(4'hE, 2'b00, 6'b000101, 4'd4, 4'h4, 99);  // SUBS -> Z
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, 99);  // BEQ taken
    do_reset(1);
    run_instr(4'h0, 2'b00, 6'b001001, 4'd2, 4'hB, 99);  // ADDEQS fails
    run_instr(4'h4, 2'b10, 6'b000000, 4'd0, 4'h0, 99);  // BMI not taken
    run_instr(4'hE, 2'b01, 6'b000001, 4'd5, 4'h0, 99);  // LDR
    run_instr(4'hE, 2'b01, 6'b000000, 4'd5, 4'h0, 99);  // STR
    run_instr(4'hE, 2'b00, 6'b000101, 4'd1, 4'h3, 99);  // SUBS -> 0011
    run_instr(4'hE, 2'b00, 6'b011111, 4'd6, 4'h8, 99);  // FMULS -> 1011
    run_instr(4'h6, 2'b10, 6'b000000, 4'd0, 4'h0, 99);  // BVS taken
    run_instr(4'h4, 2'b10, 6'b000000, 4'd0, 4'h0, 99);  // BMI taken
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, 99);  // BEQ not taken
    run_instr(4'hE, 2'b00, 6'b010101, 4'd7, 4'h4, 99);  // CMP -> 0100
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, 99);  // BEQ taken
    run_instr(4'hE, 2'b01, 6'b000000, 4'd8, 4'h0, 3);   // STR cut before MEMWR
    do_reset(1);
    run_instr(4'h1, 2'b10, 6'b000000, 4'd0, 4'h0, 99);  // BNE taken after clear
    run_instr(4'h2, 2'b10, 6'b000000, 4'd0, 4'h0, 99);  // BCS not taken
    for (int t = 0; t < 400; t++) begin
      rc   = 4'($urandom_range(0, 15));
      rop  = 2'($urandom_range(0, 3));
      rcmd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : cmds[$urandom_range(0, 5)];
      rrd  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      if ($urandom_range(0, 29) == 0) begin
        run_instr(rc, rop, {1'($urandom_range(0, 1)), rcmd, 1'($urandom_range(0, 1))}, rrd,
                  4'($urandom_range(0, 15)), $urandom_range(1, 4));
        do_reset($urandom_range(1, 2));
      end else begin
        run_instr(rc, rop, {1'($urandom_range(0, 1)), rcmd, 1'($urandom_range(0, 1))}, rrd,
                  4'($urandom_range(0, 15)), 99);
      end
    end
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
